// File: rtl/e4m3_pkg.sv
// Shared FP8 E4M3 types, field widths and special encodings, plus the
// state encoding of the shared-adder arbiter.
package e4m3_pkg;

    typedef logic [7:0] e4m3_t;

    localparam int    EXP_W    = 4;
    localparam int    MAN_W    = 3;
    localparam int    BIAS     = 7;
    localparam e4m3_t E4M3_NAN = 8'h7F;
    localparam e4m3_t E4M3_MAX = 8'h7E;  // +448, largest finite magnitude

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        RESP
    } arb_state_e;

endpackage

// File: rtl/e4m3_adder_arbiter_if.sv
// Requester/response bus of the shared E4M3 adder. The master modport is the
// client side; the slave modport is the arbiter side.
interface e4m3_adder_arbiter_if import e4m3_pkg::*; #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 resp_valid;
    logic                 resp_ready;
    e4m3_t                resp_data;
    logic [ID_W-1:0]      resp_id;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );

endinterface

// File: rtl/float_adder_e4m3.sv
// Combinational E4M3 adder: exact fixed-point sum in units of 2^-9, then
// round-to-nearest-even. Overflow saturates to +/-448; NaN in gives NaN out.
module float_adder_e4m3 import e4m3_pkg::*; (
    input  e4m3_t a,
    input  e4m3_t b,
    output e4m3_t sum
);
    localparam int MW = 20;

    function automatic logic [MW-1:0] to_fixed(input e4m3_t x);
        logic [EXP_W-1:0] e;
        logic [MAN_W:0]   m;
        e = x[MAN_W +: EXP_W];
        m = {|e, x[MAN_W-1:0]};
        return {{(MW-MAN_W-1){1'b0}}, m} << ((e == '0) ? EXP_W'(0) : e - EXP_W'(1));
    endfunction

    logic [MW-1:0] fa, fb, mag, norm;
    logic          sign, up, a_nan, b_nan;
    logic [4:0]    p;
    logic [5:0]    e;
    logic [3:0]    m;

    always_comb begin
        fa    = to_fixed(a);
        fb    = to_fixed(b);
        a_nan = &a[6:0];
        b_nan = &b[6:0];
        if (a[7] == b[7]) begin
            mag  = fa + fb;
            sign = a[7];
        end else if (fa >= fb) begin
            mag  = fa - fb;
            sign = a[7];
        end else begin
            mag  = fb - fa;
            sign = b[7];
        end
        // exact cancellation yields +0
        if (a[7] != b[7] && mag == '0) sign = 1'b0;

        p = '0;
        for (int i = 0; i < MW; i++) if (mag[i]) p = 5'(i);
        norm = mag << (5'd19 - p);
        up   = norm[15] & ((|norm[14:0]) | norm[16]);
        m    = {1'b0, norm[18:16]} + {3'b000, up};
        e    = {1'b0, p} - 6'd2 + {5'b00000, m[3]};

        if (a_nan || b_nan)                          sum = E4M3_NAN;
        else if (mag < MW'(16))                      sum = {sign, mag[6:0]};
        else if (e > 6'd15 || (e == 6'd15 && m[2:0] == 3'b111))
                                                     sum = {sign, E4M3_MAX[6:0]};
        else                                         sum = {sign, e[3:0], m[2:0]};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    int k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_i) + i;
            if (k >= N) k = k - N;
            if (!any_o && req_i[IW'(k)]) begin
                any_o           = 1'b1;
                gnt_o[IW'(k)]   = 1'b1;
                idx_o           = IW'(k);
            end
        end
    end

endmodule

// File: rtl/e4m3_adder_arbiter.sv
// Shares one E4M3 adder between NUM_REQ requesters: round-robin grant,
// registered operands, registered sum, one tagged response channel.
module e4m3_adder_arbiter import e4m3_pkg::*; #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    e4m3_adder_arbiter_if.slave   bus,
    output logic                  busy,
    output logic [15:0]           op_count
);
    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, id_q, resp_id_q;
    e4m3_t              op_a_q, op_b_q, resp_data_q, sum;
    logic [15:0]        op_count_q;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any, may_issue, fire, resp_fire;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    float_adder_e4m3 u_add (
        .a   (op_a_q),
        .b   (op_b_q),
        .sum (sum)
    );

    // rst_n gates issue so no grant is offered while reset is held
    assign resp_fire = (state_q == RESP) && bus.resp_ready;
    assign may_issue = rst_n && ((state_q == IDLE) || resp_fire);
    assign fire      = may_issue && arb_any;
    assign rr_ptr_d  = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;

    assign bus.req_ready  = fire ? arb_gnt : '0;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;
    assign busy           = (state_q != IDLE);
    assign op_count       = op_count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire) state_d = COMPUTE;
            COMPUTE: state_d = RESP;
            RESP:    if (resp_fire) state_d = fire ? COMPUTE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
            op_count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                op_a_q   <= bus.req_a[{arb_idx, 3'b000} +: 8];
                op_b_q   <= bus.req_b[{arb_idx, 3'b000} +: 8];
                id_q     <= arb_idx;
                rr_ptr_q <= rr_ptr_d;
            end
            if (state_q == COMPUTE) begin
                resp_data_q <= sum;
                resp_id_q   <= id_q;
            end
            if (resp_fire) op_count_q <= op_count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_e4m3_adder_arbiter.sv
// Directed bench for the shared E4M3 adder arbiter: vector table through the
// single-request path plus hand-written multi-cycle sequences.
module tb_e4m3_adder_arbiter;
    import e4m3_pkg::*;

    localparam int N = 4;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] op_count;
    int          errors = 0;
    int          checks = 0;

    e4m3_adder_arbiter_if #(.NUM_REQ(N)) bus ();

    e4m3_adder_arbiter #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] a, input logic [7:0] b);
        bus.req_valid[r]     = v;
        bus.req_a[r*8 +: 8]  = a;
        bus.req_b[r*8 +: 8]  = b;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Grant in this cycle, response two cycles later; returns at the RESP negedge.
    task automatic run_one(input int r, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] s, input string tag);
        @(posedge clk); #1;
        set_req(r, 1'b1, a, b);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check({tag, " grant"}, 32'(bus.req_ready), 32'(1 << r));
        @(posedge clk); #1;
        set_req(r, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check({tag, " compute"}, {30'd0, busy, bus.resp_valid}, 32'b10);
        @(negedge clk);
        check({tag, " valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, " data"}, 32'(bus.resp_data), 32'(s));
        check({tag, " id"}, 32'(bus.resp_id), 32'(r));
    endtask

    vec_t vecs[15];
    int   gq[$];
    int   rid[$];
    int   rdat[$];
    int   rtim[$];
    logic [N-1:0] g;
    logic [7:0]   exp_dat[4];
    int           nresp;

    initial begin
        vecs = '{
            '{8'h40, 8'h40, 8'h48}, '{8'h28, 8'h10, 8'h29}, '{8'h50, 8'h10, 8'h50},
            '{8'h00, 8'h00, 8'h00}, '{8'h38, 8'hB8, 8'h00}, '{8'h38, 8'h30, 8'h3C},
            '{8'h38, 8'hB0, 8'h30}, '{8'h01, 8'h01, 8'h02}, '{8'h38, 8'h18, 8'h38},
            '{8'h39, 8'h18, 8'h3A}, '{8'h7E, 8'h7E, 8'h7E}, '{8'h7F, 8'h38, 8'h7F},
            '{8'hC0, 8'h38, 8'hB8}, '{8'h3F, 8'h01, 8'h3F}, '{8'h80, 8'h80, 8'h80}
        };
        exp_dat = '{8'h48, 8'h29, 8'h50, 8'h00};

        // reset state
        do_reset();
        @(negedge clk);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst op_count", 32'(op_count), 32'd0);
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst resp_data", 32'(bus.resp_data), 32'd0);
        check("rst resp_id", 32'(bus.resp_id), 32'd0);

        // single request
        run_one(0, 8'h40, 8'h40, 8'h48, "single");
        @(negedge clk);
        check("single op_count", 32'(op_count), 32'd1);
        check("single idle", 32'(busy), 32'd0);

        // vector table across requesters
        for (int k = 0; k < 15; k++)
            run_one(k % N, vecs[k].a, vecs[k].b, vecs[k].s, $sformatf("vec%0d", k));
        @(negedge clk);
        check("table op_count", 32'(op_count), 32'd16);

        // all four valid from reset
        do_reset();
        set_req(0, 1'b1, 8'h40, 8'h40);
        set_req(1, 1'b1, 8'h28, 8'h10);
        set_req(2, 1'b1, 8'h50, 8'h10);
        set_req(3, 1'b1, 8'h00, 8'h00);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                rid.push_back(int'(bus.resp_id));
                rdat.push_back(int'(bus.resp_data));
                rtim.push_back(c);
            end
            g = bus.req_ready;
            for (int i = 0; i < N; i++) if (g[i]) gq.push_back(i);
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (g[i]) bus.req_valid[i] = 1'b0;
        end
        check("all4 grants", 32'(gq.size()), 32'd4);
        check("all4 resps", 32'(rid.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("all4 grant%0d", i), (i < gq.size()) ? gq[i] : -1, i);
            check($sformatf("all4 id%0d", i), (i < rid.size()) ? rid[i] : -1, i);
            check($sformatf("all4 data%0d", i), (i < rdat.size()) ? rdat[i] : -1, 32'(exp_dat[i]));
            check($sformatf("all4 time%0d", i), (i < rtim.size()) ? rtim[i] : -1, 2 + 2 * i);
        end
        check("all4 op_count", 32'(op_count), 32'd4);

        // backpressure with req1 pending
        do_reset();
        bus.resp_ready = 1'b0;
        set_req(0, 1'b1, 8'h38, 8'h38);
        @(negedge clk);
        check("bp grant0", 32'(bus.req_ready), 32'b0001);
        @(posedge clk); #1;
        set_req(0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b1, 8'h40, 8'h40);
        @(negedge clk);
        check("bp compute ready", 32'(bus.req_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d valid", c), 32'(bus.resp_valid), 32'd1);
            check($sformatf("bp%0d data", c), 32'(bus.resp_data), 32'h40);
            check($sformatf("bp%0d id", c), 32'(bus.resp_id), 32'd0);
            check($sformatf("bp%0d ready", c), 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp grant1", 32'(bus.req_ready), 32'b0010);
        @(posedge clk); #1;
        set_req(1, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check("bp compute1", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        check("bp resp1 data", 32'(bus.resp_data), 32'h48);
        check("bp resp1 id", 32'(bus.resp_id), 32'd1);
        check("bp op_count", 32'(op_count), 32'd1);

        // fairness between req0 and req2
        do_reset();
        gq.delete();
        set_req(0, 1'b1, 8'h40, 8'h40);
        set_req(2, 1'b1, 8'h38, 8'h38);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            g = bus.req_ready;
            for (int i = 0; i < N; i++) if (g[i]) gq.push_back(i);
        end
        check("fair count", 32'(gq.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("fair grant%0d", i), (i < gq.size()) ? gq[i] : -1, (i % 2) * 2);

        // async reset during COMPUTE
        do_reset();
        set_req(0, 1'b1, 8'h40, 8'h40);
        @(negedge clk);
        check("ar grant", 32'(bus.req_ready), 32'b0001);
        @(posedge clk); #2;
        check("ar busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar resp_valid", 32'(bus.resp_valid), 32'd0);
        check("ar busy", 32'(busy), 32'd0);
        check("ar req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #2;
        bus.req_valid = '0;
        rst_n = 1'b1;
        nresp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid) nresp++;
        end
        check("ar no resp", 32'(nresp), 32'd0);
        check("ar op_count", 32'(op_count), 32'd0);

        // op_count wrap, counter preloaded near the top
        do_reset();
        @(negedge clk);
        force dut.op_count_q = 16'hFFFE;
        #1 release dut.op_count_q;
        #1 check("wrap preload", 32'(op_count), 32'hFFFE);
        run_one(1, 8'h40, 8'h40, 8'h48, "wrap1");
        @(negedge clk);
        check("wrap1 count", 32'(op_count), 32'hFFFF);
        check("wrap idle busy", 32'(busy), 32'd0);
        run_one(2, 8'h28, 8'h10, 8'h29, "wrap2");
        @(negedge clk);
        check("wrap2 count", 32'(op_count), 32'h0000);
        check("wrap2 busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/e4m3_adder_arbiter.md
Name: e4m3_adder_arbiter

Overview:
- Shares one combinational float_adder_e4m3 (FP8 E4M3, 8-bit operands, 8-bit sum) between NUM_REQ independent requesters.
- Arbitration is round-robin. The block registers the granted operands, registers the adder output, and returns the sum on a single response channel tagged with the requester ID.
- Sits between the FP8 compute clients (accumulators, dot-product lanes) and the shared adder datapath.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ), width of requester ID; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*8  packed operand A; requester i uses bits [8i+7:8i].
- req_b  in  NUM_REQ*8  packed operand B; same packing as req_a.
- req_ready  out  NUM_REQ  grant; one-hot or zero; request accepted when req_valid[i] && req_ready[i].
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  8  E4M3 sum.
- resp_id  out  ID_W  index of the requester that owns resp_data.
- busy  out  1  high when FSM is not IDLE.
- op_count  out  16  number of completed responses; wraps 0xFFFF -> 0x0000.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, op_a=op_b=0, resp_data=0, resp_id=0, resp_valid=0, req_ready=0, busy=0, op_count=0.
- Reset asserted mid-operation: clears everything immediately, including an in-flight operation or held response. The discarded operation is not retried and is not counted.
- Arbiter (combinational):
  - Scan req_valid starting at rr_ptr, ascending, wrapping modulo NUM_REQ; first set bit = winner g.
  - A grant happens only when the FSM may issue (see below); req_ready[g]=1 that cycle, all other bits 0.
  - On a grant: op_a <= req_a[g], op_b <= req_b[g], id_q <= g, rr_ptr <= (g+1) mod NUM_REQ.
- FSM states:
  - IDLE: may issue. On grant -> COMPUTE; otherwise stay in IDLE.
  - COMPUTE: adder input is op_a/op_b. At the clock edge, resp_data <= adder sum and resp_id <= id_q -> RESP. No grant in this state.
  - RESP: resp_valid=1. If resp_ready=0, stay; resp_data and resp_id stay stable; no grant.
  - RESP with resp_ready=1: op_count increments. If any req_valid, a grant occurs in the same cycle -> COMPUTE; else -> IDLE.
- Latency: grant in cycle T -> resp_valid high in cycle T+2.
- Throughput: one result per 2 cycles under continuous demand and resp_ready=1.
- Requester rule: req_valid and operands must be held stable until req_ready. Dropping req_valid before grant is legal; that requester is simply skipped.
- Simultaneous events:
  - resp_ready and a new request in the same RESP cycle are both honoured.
  - Multiple req_valid bits resolve by rr_ptr only; no fixed priority.
- Arithmetic: no arithmetic is performed in this block beyond rr_ptr wrap and op_count. The sum is exactly the float_adder_e4m3 output for (op_a, op_b).
- busy = (state != IDLE).

Decomposition:
- Shared package e4m3_pkg holds:
  - e4m3_t (8-bit logic) and the field widths EXP_W=4, MAN_W=3.
  - The arbiter FSM state enum {IDLE, COMPUTE, RESP}.
  - Shared constants for later FP8 blocks.
- One natural sub-module, rr_arbiter: NUM_REQ request vector in, rr_ptr in, one-hot grant and encoded index out. It is reusable by future shared FP8 units.
- float_adder_e4m3 is instantiated unchanged.

Test Plan:
- Single request: after reset, req_valid[0]=1, a=0x40, b=0x40 -> req_ready[0] high in the same cycle; 2 cycles later resp_valid=1, resp_data=0x48, resp_id=0; op_count=1 after the handshake.
- All four valid from reset:
  - operands req0 0x40/0x40, req1 0x28/0x10, req2 0x50/0x10, req3 0x00/0x00.
  - resp_ready=1.
  - Required: grants in order 0,1,2,3; responses (id,data) = (0,0x48), (1,0x29), (2,0x50), (3,0x00), spaced 2 cycles apart.
- Backpressure: resp_ready=0 for 5 cycles during RESP with req1 pending -> resp_valid, resp_data and resp_id stable; req_ready=0 throughout; req1 granted in the cycle resp_ready rises.
- Fairness: req0 and req2 held valid continuously -> grant sequence 0,2,0,2,0,2; req1 and req3 never granted.
- Async reset mid-op: drop rst_n during COMPUTE, off a clock edge -> resp_valid, busy and req_ready go to 0 immediately. After release, with no req_valid: no response and op_count=0.
- op_count wrap: force 65536 completed responses -> op_count reads 0x0000; busy low in IDLE between bursts.
